pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 53 +++++
 rtl/hazard_cmp.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline package: hazard FSM states, control bundle and
// default timing for the hazard controller.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_ERR      = 2'd3
  } hz_state_e;

  localparam int unsigned INIT_CYCLES_DEF = 3;
  localparam int unsigned TIMEOUT_DEF     = 16;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_flush;
    logic pipe_hold;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_INIT = '{
    pc_en: 1'b0, ifid_en: 1'b0,
    ifid_flush: 1'b1, idex_flush: 1'b1,
    pipe_hold: 1'b0
  };

  localparam hz_ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, ifid_en: 1'b1,
    ifid_flush: 1'b0, idex_flush: 1'b0,
    pipe_hold: 1'b0
  };

  localparam hz_ctrl_t CTRL_BR = '{
    pc_en: 1'b1, ifid_en: 1'b1,
    ifid_flush: 1'b1, idex_flush: 1'b1,
    pipe_hold: 1'b0
  };

  localparam hz_ctrl_t CTRL_LU = '{
    pc_en: 1'b0, ifid_en: 1'b0,
    ifid_flush: 1'b0, idex_flush: 1'b1,
    pipe_hold: 1'b0
  };

  localparam hz_ctrl_t CTRL_HOLD = '{
    pc_en: 1'b0, ifid_en: 1'b0,
    ifid_flush: 1'b0, idex_flush: 1'b0,
    pipe_hold: 1'b1
  };

endpackage

// File: rtl/hazard_cmp.sv
// Load-use compare: a load in EX writing a register that the
// instruction in ID actually reads. x0 never creates a hazard.
module hazard_cmp (
  input  logic       md_ex,
  input  logic [4:0] rd_ex,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       use_rs1_id,
  input  logic       use_rs2_id,
  output logic       hazard
);

  logic hit1;
  logic hit2;

  assign hit1 = use_rs1_id && (rs1_id == rd_ex);
  assign hit2 = use_rs2_id && (rs2_id == rd_ex);

  assign hazard = md_ex
               && (rd_ex != 5'd0)
               && (hit1 || hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: post-reset clear, memory stall with
// timeout, branch flush and load-use stall.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MD_ex,
  input  logic [4:0]  RD_ex,
  input  logic [4:0]  RS1_id,
  input  logic [4:0]  RS2_id,
  input  logic        use_rs1_id,
  input  logic        use_rs2_id,
  input  logic        branch_taken_ex,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        pipe_hold,
  output logic        err,
  output logic [15:0] stall_cnt
);

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  hz_state_e   state;
  hz_state_e   state_nx;
  hz_ctrl_t    ctrl;
  logic [3:0]  init_cnt;
  logic [7:0]  wait_cnt;
  logic        err_q;
  logic [15:0] stall_q;
  logic        lu_hazard;
  logic        hold;

  hazard_cmp u_cmp (
    .md_ex      (MD_ex),
    .rd_ex      (RD_ex),
    .rs1_id     (RS1_id),
    .rs2_id     (RS2_id),
    .use_rs1_id (use_rs1_id),
    .use_rs2_id (use_rs2_id),
    .hazard     (lu_hazard)
  );

  // In MEM_WAIT only mem_ready matters; a completing cycle is plain RUN.
  assign hold = (state == S_MEM_WAIT) ? !mem_ready
                                      : (mem_req && !mem_ready);

  always_comb begin
    ctrl     = CTRL_RUN;
    state_nx = state;
    unique case (state)
      S_INIT: begin
        ctrl = CTRL_INIT;
        if (init_cnt == INIT_LAST) state_nx = S_RUN;
      end
      S_RUN, S_MEM_WAIT: begin
        if (hold) begin
          ctrl = CTRL_HOLD;
          if (state == S_RUN)
            state_nx = S_MEM_WAIT;
          else if (wait_cnt == TO_LAST)
            state_nx = S_ERR;
        end else begin
          state_nx = S_RUN;
          if (branch_taken_ex)
            ctrl = CTRL_BR;
          else if (lu_hazard)
            ctrl = CTRL_LU;
        end
      end
      S_ERR: ctrl = CTRL_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_INIT;
      init_cnt <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
      stall_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == S_INIT)
        init_cnt <= init_cnt + 4'd1;
      // Held at zero outside MEM_WAIT, so it starts clear on entry.
      if (state == S_MEM_WAIT)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= '0;
      if (state_nx == S_ERR)
        err_q <= 1'b1;
      if (!ctrl.pc_en && (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'd1;
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign ifid_en    = ctrl.ifid_en;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_flush = ctrl.idex_flush;
  assign pipe_hold  = ctrl.pipe_hold;
  assign err        = err_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-scenario tasks with an
// expected-output queue filled before stimulus and drained per cycle.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MD_ex = 1'b0;
  logic [4:0]  RD_ex = '0;
  logic [4:0]  RS1_id = '0;
  logic [4:0]  RS2_id = '0;
  logic        use_rs1_id = 1'b0;
  logic        use_rs2_id = 1'b0;
  logic        branch_taken_ex = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        pipe_hold;
  logic        err;
  logic [15:0] stall_cnt;

  // {pc_en, ifid_en, ifid_flush, idex_flush, pipe_hold, err}
  localparam logic [5:0] V_INIT = 6'b001100;
  localparam logic [5:0] V_RUN  = 6'b110000;
  localparam logic [5:0] V_LU   = 6'b000100;
  localparam logic [5:0] V_BR   = 6'b111100;
  localparam logic [5:0] V_MEM  = 6'b000010;
  localparam logic [5:0] V_ERR  = 6'b000011;
  localparam int         TO     = 16;

  logic [5:0]  exp_q[$];
  logic [5:0]  obs;
  logic [15:0] sc_exp;
  int          n_chk = 0;
  int          n_err = 0;

  pipe_hazard_ctrl #(
    .INIT_CYCLES (3),
    .TIMEOUT     (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .MD_ex           (MD_ex),
    .RD_ex           (RD_ex),
    .RS1_id          (RS1_id),
    .RS2_id          (RS2_id),
    .use_rs1_id      (use_rs1_id),
    .use_rs2_id      (use_rs2_id),
    .branch_taken_ex (branch_taken_ex),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .pipe_hold       (pipe_hold),
    .err             (err),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] sample();
    return {pc_en, ifid_en, ifid_flush, idex_flush, pipe_hold, err};
  endfunction

  // One cycle: drive just after posedge, sample at negedge.
  task automatic drv(input int md, rd, r1, r2, u1, u2,
                     input int br, mq, mr);
    @(posedge clk);
    #1;
    MD_ex           = md[0];
    RD_ex           = rd[4:0];
    RS1_id          = r1[4:0];
    RS2_id          = r2[4:0];
    use_rs1_id      = u1[0];
    use_rs2_id      = u2[0];
    branch_taken_ex = br[0];
    mem_req         = mq[0];
    mem_ready       = mr[0];
    @(negedge clk);
    obs = sample();
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset(input string tag);
    logic [5:0] e;
    // Assert mid-cycle, away from any edge: must act without a clock.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    obs = sample();
    sc_exp = '0;
    exp_q.push_back(V_INIT);
    e = exp_q.pop_front();
    n_chk++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL %s async got %b exp %b", tag, obs, e);
    end
    n_chk++;
    if (stall_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL %s async stall_cnt got %0d exp 0", tag, stall_cnt);
    end
    repeat (2) idle();
    exp_q.push_back(V_INIT);
    exp_q.push_back(V_INIT);
    exp_q.push_back(V_INIT);
    exp_q.push_back(V_RUN);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        obs = sample();
      end else begin
        idle();
      end
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL %s rel[%0d] got %b exp %b", tag, i, obs, e);
      end
      n_chk++;
      if (stall_cnt !== sc_exp) begin
        n_err++;
        $display("FAIL %s rel[%0d] stall_cnt got %0d exp %0d",
                 tag, i, stall_cnt, sc_exp);
      end
      if (!e[5]) sc_exp++;
    end
  endtask

  task automatic test_load_use();
    logic [5:0] e;
    exp_q.push_back(V_LU);
    exp_q.push_back(V_RUN);
    exp_q.push_back(V_RUN);
    exp_q.push_back(V_RUN);
    exp_q.push_back(V_LU);
    exp_q.push_back(V_RUN);
    exp_q.push_back(V_RUN);
    exp_q.push_back(V_LU);
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: drv(1, 5, 0, 5, 0, 1, 0, 0, 0);
        1: idle();
        2: drv(1, 0, 0, 5, 0, 1, 0, 0, 0);
        3: drv(1, 0, 0, 0, 0, 1, 0, 0, 0);
        4: drv(1, 7, 7, 3, 1, 0, 0, 0, 0);
        5: drv(1, 7, 7, 7, 0, 0, 0, 0, 0);
        6: drv(0, 7, 7, 7, 1, 1, 0, 0, 0);
        default: drv(1, 31, 2, 31, 1, 1, 0, 0, 0);
      endcase
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL load_use[%0d] got %b exp %b", i, obs, e);
      end
      n_chk++;
      if (stall_cnt !== sc_exp) begin
        n_err++;
        $display("FAIL load_use[%0d] stall_cnt got %0d exp %0d",
                 i, stall_cnt, sc_exp);
      end
      if (!e[5]) sc_exp++;
    end
  endtask

  task automatic test_branch();
    logic [5:0] e;
    exp_q.push_back(V_BR);
    exp_q.push_back(V_BR);
    exp_q.push_back(V_RUN);
    exp_q.push_back(V_RUN);
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drv(1, 5, 0, 5, 0, 1, 1, 0, 0);
        1: drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
        2: idle();
        default: drv(0, 0, 0, 0, 0, 0, 0, 1, 1);
      endcase
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL branch[%0d] got %b exp %b", i, obs, e);
      end
      n_chk++;
      if (stall_cnt !== sc_exp) begin
        n_err++;
        $display("FAIL branch[%0d] stall_cnt got %0d exp %0d",
                 i, stall_cnt, sc_exp);
      end
      if (!e[5]) sc_exp++;
    end
  endtask

  task automatic test_mem_wait();
    logic [5:0] e;
    int         hold_n;
    hold_n = 0;
    repeat (4) exp_q.push_back(V_MEM);
    exp_q.push_back(V_RUN);
    exp_q.push_back(V_RUN);
    exp_q.push_back(V_MEM);
    exp_q.push_back(V_BR);
    exp_q.push_back(V_MEM);
    exp_q.push_back(V_LU);
    exp_q.push_back(V_RUN);
    for (int i = 0; i < 11; i++) begin
      case (i)
        0, 1, 2, 3, 6, 8: drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        4: drv(0, 0, 0, 0, 0, 0, 0, 1, 1);
        7: drv(1, 4, 0, 4, 0, 1, 1, 1, 1);
        9: drv(1, 4, 4, 0, 1, 0, 0, 1, 1);
        default: idle();
      endcase
      if (i < 6 && pipe_hold) hold_n++;
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL mem_wait[%0d] got %b exp %b", i, obs, e);
      end
      n_chk++;
      if (stall_cnt !== sc_exp) begin
        n_err++;
        $display("FAIL mem_wait[%0d] stall_cnt got %0d exp %0d",
                 i, stall_cnt, sc_exp);
      end
      if (!e[5]) sc_exp++;
    end
    n_chk++;
    if (hold_n != 4) begin
      n_err++;
      $display("FAIL mem_wait hold_cycles got %0d exp 4", hold_n);
    end
  endtask

  task automatic test_mid_wait_reset();
    logic [5:0] e;
    exp_q.push_back(V_MEM);
    exp_q.push_back(V_MEM);
    for (int i = 0; i < 2; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL mid_wait[%0d] got %b exp %b", i, obs, e);
      end
      if (!e[5]) sc_exp++;
    end
    test_reset("mid_wait_reset");
  endtask

  task automatic test_timeout();
    logic [5:0] e;
    // One RUN detect cycle plus TO cycles in MEM_WAIT, then ERR.
    repeat (TO + 1) exp_q.push_back(V_MEM);
    repeat (3) exp_q.push_back(V_ERR);
    for (int i = 0; i < TO + 4; i++) begin
      if (i <= TO + 1)
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
      else
        drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
      e = exp_q.pop_front();
      n_chk++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL timeout[%0d] got %b exp %b", i, obs, e);
      end
      n_chk++;
      if (stall_cnt !== sc_exp) begin
        n_err++;
        $display("FAIL timeout[%0d] stall_cnt got %0d exp %0d",
                 i, stall_cnt, sc_exp);
      end
      if (!e[5]) sc_exp++;
    end
    test_reset("err_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    sc_exp = '0;
    test_reset("reset");
    test_load_use();
    test_branch();
    test_mem_wait();
    test_mid_wait_reset();
    test_timeout();
    idle();
    n_chk++;
    if (sample() !== V_RUN) begin
      n_err++;
      $display("FAIL post_err_run got %b exp %b", sample(), V_RUN);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
